// File: rtl/small_poly_expand_seq.sv
// small_poly_expand_seq: streams one polynomial of N signed SW-bit coefficients
// from the small-poly memory and expands each one into [0, Q). The result is
// presented as a CW-bit coefficient on a valid/ready output stream.
// Optional feature macro: SMALL_RANGE_CHECK_EN. When it is defined, a sticky
// err flag reports any coefficient with |s| > ETA.
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// out_valid comes only from registered buffer occupancy, so it never depends
// combinationally on out_ready. The head entry stays put until it is accepted.
// The memory read is fire-and-forget: rd_data is valid exactly one cycle after
// rd_en.
module small_poly_expand_seq #(
  parameter int N  = 256,
  parameter int SW = 3,
  parameter int CW = 12,
  parameter int Q  = 3329
`ifdef SMALL_RANGE_CHECK_EN
  ,
  parameter int ETA = 2
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [$clog2(N)-1:0] rd_addr,
  input  logic [SW-1:0]        rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_coeff,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 err,
  output logic [1:0]           state_dbg
);

  localparam int AW = $clog2(N);
  localparam logic [AW:0]   N_CNT    = (AW+1)'(N);
  localparam logic [AW:0]   LAST_CNT = (AW+1)'(N - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [CW-1:0] Q_CW     = CW'(Q);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [AW:0]   rd_cnt;
  logic          rd_pending;
  logic [AW-1:0] rd_idx_q;

  logic [CW-1:0] buf_coeff [2];
  logic [AW-1:0] buf_idx   [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;

  logic          push, pop, credit_ok;
  logic [2:0]    occ_after_pop;
  logic [CW-1:0] s_cw, expanded;

  assign state_dbg = state;
  assign rd_addr   = rd_cnt[AW-1:0];

  // Buffer head drives the output stream.
  assign out_valid = (count != 2'd0);
  assign out_coeff = buf_coeff[rd_ptr];
  assign out_idx   = buf_idx[rd_ptr];
  assign out_last  = out_valid && (out_idx == LAST_IDX);

  assign push = rd_pending;
  assign pop  = out_valid && out_ready;

  // Another read may issue only if it still fits in the buffer. This counts
  // the slot freed by a pop in this same cycle, so full rate keeps streaming.
  assign occ_after_pop = {1'b0, count} + {2'b0, rd_pending} - {2'b0, pop};
  assign credit_ok     = (occ_after_pop < 3'd2);

  // Small-to-mod-q expansion: negative s maps to Q + s. The add wraps
  // correctly in CW bits because Q + s is always in range.
  assign s_cw     = {{(CW-SW){rd_data[SW-1]}}, rd_data};
  assign expanded = rd_data[SW-1] ? (s_cw + Q_CW) : s_cw;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic, read issue and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (credit_ok && (rd_cnt < N_CNT)) begin
          rd_en = 1'b1;
          if (rd_cnt == LAST_CNT) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pop && out_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read address counter, restarted by an accepted start.
  always_ff @(posedge clk) begin
    if (rst)                           rd_cnt <= '0;
    else if (state == S_IDLE && start) rd_cnt <= '0;
    else if (rd_en)                    rd_cnt <= rd_cnt + 1'b1;
  end

  // Track the one-cycle read latency and the index of the returning word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      rd_pending <= rd_en;
      rd_idx_q   <= rd_addr;
    end
  end

  // Two-entry output FIFO holding {coeff, idx}.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_coeff[0] <= '0;
      buf_coeff[1] <= '0;
      buf_idx[0]   <= '0;
      buf_idx[1]   <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      if (push) begin
        buf_coeff[wr_ptr] <= expanded;
        buf_idx[wr_ptr]   <= rd_idx_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef SMALL_RANGE_CHECK_EN
  localparam logic signed [SW:0] ETA_S = (SW+1)'(ETA);

  logic signed [SW:0] s_ext;
  logic               out_of_range;

  assign s_ext        = {rd_data[SW-1], rd_data};
  assign out_of_range = (s_ext > ETA_S) || (s_ext < -ETA_S);

  // Sticky range flag: set when an oversized word enters the buffer and
  // cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (rst)                           err <= 1'b0;
    else if (state == S_IDLE && start) err <= 1'b0;
    else if (push && out_of_range)     err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
